// File: rtl/wb_stream_master.sv
// ---------------------------------------------------------------------------
// wb_stream_master
//
// Bridges a valid/ready command stream onto a pipelined Wishbone master and
// returns one response per command. Exactly one bus transaction is in flight
// at a time: IDLE -> REQ -> (WAIT) -> RESP -> IDLE.
//
// Configuration macro:
//   WB_STREAM_MASTER_TIMEOUT_EN  when defined, a bus transaction that sees no
//                                ack within TIMEOUT bus cycles is abandoned and
//                                answered with rsp_err=1. When undefined the
//                                block waits for ack forever and rsp_err=0.
//
// Parameters:
//   CFGAW    address width (command and Wishbone)
//   CFGDW    data width (command and Wishbone)
//   TIMEOUT  maximum bus cycles per transaction, 2..65535
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_we/cmd_addr/cmd_data    command: 1=write, target address, write data
//   rsp_valid/rsp_ready         response handshake
//   rsp_data/rsp_err            read data (0 for writes/errors), timeout flag
//   cyc_o/stb_o/we_o            Wishbone master request strobes
//   addr_o/data_o               Wishbone address and write data
//   ack_i/stall_i/data_i        Wishbone slave response
// ---------------------------------------------------------------------------
module wb_stream_master #(
  parameter int CFGAW   = 32,
  parameter int CFGDW   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [CFGAW-1:0] cmd_addr,
  input  logic [CFGDW-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [CFGDW-1:0] rsp_data,
  output logic             rsp_err,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [CFGAW-1:0] addr_o,
  output logic [CFGDW-1:0] data_o,
  input  logic             ack_i,
  input  logic             stall_i,
  input  logic [CFGDW-1:0] data_i
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_stream_master: TIMEOUT must lie in 2..65535");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             we_q, we_d;
  logic [CFGAW-1:0] addr_q, addr_d;
  logic [CFGDW-1:0] data_q, data_d;
  logic [CFGDW-1:0] rsp_data_q, rsp_data_d;

  logic on_bus;    // a bus cycle is open (REQ or WAIT)
  logic ack_ok;    // an ack that actually completes the transaction
  logic timeout;   // give up on the current transaction this cycle
  logic accept;    // command handshake this cycle

  assign on_bus = (state_q == S_REQ) || (state_q == S_WAIT);

  // An ack only counts once the request has been taken (no stall) or while
  // waiting; acks in IDLE, RESP or during a stalled request are noise.
  assign ack_ok = ack_i && (((state_q == S_REQ) && !stall_i) || (state_q == S_WAIT));

  // Gating with rst keeps an upstream source from seeing a handshake that
  // reset is about to discard.
  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

`ifdef WB_STREAM_MASTER_TIMEOUT_EN
  localparam int CNTW = 16;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            rsp_err_q;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (on_bus) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // cnt_q counts completed bus cycles, so the TIMEOUT-th cycle is the one
  // where cnt_q == TIMEOUT-1; an ack arriving in that very cycle still wins.
  assign timeout = on_bus && (cnt_q == CNT_LAST) && !ack_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (on_bus && (ack_ok || timeout)) begin
        rsp_err_q <= timeout;
      end else if ((state_q == S_RESP) && rsp_ready) begin
        rsp_err_q <= 1'b0;
      end
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-state signal is given its hold value first so that no
    // path through the case statement leaves one unassigned (no latches).
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_REQ;
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          data_d  = cmd_data;
        end
      end

      S_REQ, S_WAIT: begin
        if (ack_ok || timeout) begin
          state_d    = S_RESP;
          rsp_data_d = (ack_ok && !we_q) ? data_i : '0;
          // Bus-side request fields read as zero whenever cyc_o is low.
          we_d       = 1'b0;
          addr_d     = '0;
          data_d     = '0;
        end else if ((state_q == S_REQ) && !stall_i) begin
          state_d = S_WAIT;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d    = S_IDLE;
          rsp_data_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign cyc_o     = on_bus;
  assign stb_o     = (state_q == S_REQ);
  assign we_o      = we_q;
  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;

endmodule
